// File: rtl/pixel_stream_buffer.sv
// pixel_stream_buffer: elastic PPU-to-VGA pixel FIFO that owns the raster counter.
// Define PIXBUF_UNDERFLOW_HOLD_EN to repeat the last popped pixel on underflow.
module pixel_stream_buffer #(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4,
  parameter int HA_END    = 639,
  parameter int VA_END    = 479,
  parameter int LINE      = 799,
  parameter int SCREEN    = 524
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_stb,
  output logic                 in_ack,
  output logic [7:0]           pix_data,
  output logic                 pix_de,
  output logic                 frame_sync,
  output logic [ADDR_BITS:0]   level,
  output logic [15:0]          underflow_cnt
);

  localparam int XW = $clog2(LINE + 1);
  localparam int YW = $clog2(SCREEN + 1);

  localparam logic [ADDR_BITS:0]   LVL_FULL = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   LVL_ONE  = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

  logic [XW-1:0]        sx;
  logic [YW-1:0]        sy;
  logic [7:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0] wptr;
  logic [ADDR_BITS-1:0] rptr;
  logic                 line_end;
  logic                 active;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 under;
  logic [7:0]           fill;

  // Raster decode and FIFO handshake qualifiers from cycle-start state
  always_comb begin
    line_end = (sx == XW'(LINE));
    active   = (sx <= XW'(HA_END)) && (sy <= YW'(VA_END));
    empty    = (level == '0);
    full     = (level == LVL_FULL);
    push     = in_stb && !in_ack && !full;
    pop      = active && !empty;
    under    = active && empty;
  end

  assign frame_sync = (sx == '0) && (sy == '0);

  // Free-running raster counter, independent of FIFO state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx <= '0;
      sy <= '0;
    end else if (line_end) begin
      sx <= '0;
      sy <= (sy == YW'(SCREEN)) ? '0 : sy + YW'(1);
    end else begin
      sx <= sx + XW'(1);
    end
  end

  // FIFO storage; contents are don't-care once level is cleared
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_data;
    end
  end

  // Pointers, occupancy and the one-cycle accept pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      in_ack <= 1'b0;
    end else begin
      in_ack <= push;
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Saturating count of pops attempted while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_cnt <= '0;
    end else if (under && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

`ifdef PIXBUF_UNDERFLOW_HOLD_EN
  logic [7:0] hold;

  // Remember the last real pixel so underflow repeats it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= 8'h00;
    end else if (pop) begin
      hold <= mem[rptr];
    end
  end

  assign fill = hold;
`else
  assign fill = 8'h00;
`endif

  // Registered pixel output, one cycle behind the raster position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_data <= 8'h00;
      pix_de   <= 1'b0;
    end else begin
      pix_de <= active;
      unique case (1'b1)
        pop:     pix_data <= mem[rptr];
        under:   pix_data <= fill;
        default: pix_data <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// tb_pixel_stream_buffer: scoreboard bench on a shrunken raster,
// plus an all-active instance that drives the underflow counter to saturation.
`timescale 1ns/1ps
module tb_pixel_stream_buffer;

  localparam int HA = 9;
  localparam int VA = 3;
  localparam int LN = 19;
  localparam int SC = 5;

`ifdef PIXBUF_UNDERFLOW_HOLD_EN
  localparam logic [7:0] FILLC = 8'h33;
`else
  localparam logic [7:0] FILLC = 8'h00;
`endif

  typedef struct {
    logic [7:0] d;
    int         acc;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_s = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_stb = 1'b0;

  logic       in_ack;
  logic [7:0] pix_data;
  logic       pix_de;
  logic       frame_sync;
  logic [4:0] level;
  logic [15:0] underflow_cnt;

  logic       s_ack;
  logic [7:0] s_pix;
  logic       s_de;
  logic       s_fs;
  logic [4:0] s_level;
  logic [15:0] s_ucnt;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  bit sat_done = 1'b0;

  ent_t       sbq[$];
  logic [7:0] wbuf [32];
  int         acc_e [32];

  int         mx = 0;
  int         my = 0;
  logic       m_de = 1'b0;
  logic [15:0] m_ucnt = '0;
  logic [7:0] m_last = 8'h00;
  logic [7:0] ex_m;
  ent_t       e_m;

  pixel_stream_buffer #(
    .DEPTH(16), .ADDR_BITS(4),
    .HA_END(HA), .VA_END(VA), .LINE(LN), .SCREEN(SC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
    .pix_data(pix_data), .pix_de(pix_de),
    .frame_sync(frame_sync), .level(level),
    .underflow_cnt(underflow_cnt)
  );

  pixel_stream_buffer #(
    .DEPTH(16), .ADDR_BITS(4),
    .HA_END(3), .VA_END(1), .LINE(3), .SCREEN(1)
  ) u_sat (
    .clk(clk), .rst(rst_s),
    .in_data(8'h5A), .in_stb(1'b0), .in_ack(s_ack),
    .pix_data(s_pix), .pix_de(s_de),
    .frame_sync(s_fs), .level(s_level),
    .underflow_cnt(s_ucnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Reference raster position and expected data-enable
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mx   <= 0;
      my   <= 0;
      m_de <= 1'b0;
    end else begin
      m_de <= (mx <= HA) && (my <= VA);
      if (mx == LN) begin
        mx <= 0;
        my <= (my == SC) ? 0 : my + 1;
      end else begin
        mx <= mx + 1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows an active pixel
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      m_ucnt = '0;
      m_last = 8'h00;
    end else begin
      chk("frame_sync", int'(frame_sync), int'(mx == 0 && my == 0));
      chk("pix_de", int'(pix_de), int'(m_de));
      if (pix_de) begin
        if (sbq.size() > 0 && sbq[0].acc < cyc) begin
          e_m = sbq.pop_front();
          ex_m = e_m.d;
          m_last = e_m.d;
        end else begin
`ifdef PIXBUF_UNDERFLOW_HOLD_EN
          ex_m = m_last;
`else
          ex_m = 8'h00;
`endif
          if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
        end
        chk("pix_data", int'(pix_data), int'(ex_m));
      end else begin
        chk("blank_data", int'(pix_data), 0);
      end
      chk("underflow_cnt", int'(underflow_cnt), int'(m_ucnt));
      chk("level", int'(level), sbq.size());
    end
  end

  task automatic wait_pos(input int x, input int y);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(mx == x && my == y) && g < 400);
    if (!(mx == x && my == y)) begin
      vectors++;
      errs++;
      $display("FAIL wait_pos: got (%0d,%0d), expected (%0d,%0d)", mx, my, x, y);
    end
  endtask

  // PPU-like driver: holds stb/data until ack, then offers the next word
  task automatic drive(input int n);
    int   w;
    ent_t e;
    for (int i = 0; i < n; i++) begin
      in_data = wbuf[i];
      in_stb  = 1'b1;
      w = 0;
      do begin
        @(posedge clk);
        #1;
        w++;
      end while (!in_ack && w < 200);
      if (!in_ack) begin
        vectors++;
        errs++;
        $display("FAIL ack_timeout: got no ack, expected ack for word %0d", i);
        in_stb = 1'b0;
        return;
      end
      e.d = wbuf[i];
      e.acc = cyc;
      sbq.push_back(e);
      acc_e[i] = cyc;
    end
    in_stb = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    in_stb = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int fs;
    int de;
    int pop_edge;
    int g;
    logic [7:0] seq_exp [5];

    pop_edge = 0;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_ack", int'(in_ack), 0);
    chk("rst_pix", int'(pix_data), 0);
    chk("rst_de", int'(pix_de), 0);
    chk("rst_sync", int'(frame_sync), 1);
    chk("rst_level", int'(level), 0);
    chk("rst_uf", int'(underflow_cnt), 0);
    rst = 1'b0;

    fs = 0;
    de = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      fs += int'(frame_sync);
      de += int'(pix_de);
    end
    chk("frame_pulses", fs, 1);
    chk("de_cycles", de, 40);
    chk("sync_wrap", int'(frame_sync), 1);
    chk("uf_frame", int'(underflow_cnt), 40);

    wait_pos(0, 4);
    for (int i = 0; i < 17; i++) wbuf[i] = 8'hA5 ^ 8'(i);
    fork
      drive(17);
      begin
        wait_pos(0, 0);
        chk("level_full", int'(level), 16);
        chk("ack_idle_full", int'(in_ack), 0);
        pop_edge = cyc + 1;
      end
    join
    for (int i = 1; i < 16; i++) chk("ack_spacing", acc_e[i] - acc_e[i-1], 2);
    chk("ack_after_pop", acc_e[16], pop_edge + 1);
    wait_pos(0, 4);

    do_reset();
    wait_pos(0, 4);
    chk("uf_rows", int'(underflow_cnt), 40);
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    wbuf[2] = 8'h33;
    drive(3);
    wait_pos(0, 0);
    seq_exp[0] = 8'h11;
    seq_exp[1] = 8'h22;
    seq_exp[2] = 8'h33;
    seq_exp[3] = FILLC;
    seq_exp[4] = FILLC;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("seq_pix", int'(pix_data), int'(seq_exp[i]));
    end
    chk("seq_uf", int'(underflow_cnt), 42);

    wait_pos(0, 4);
    for (int i = 0; i < 7; i++) wbuf[i] = 8'h40 + 8'(i);
    drive(7);
    @(negedge clk);
    chk("level_7", int'(level), 7);
    #2;
    rst = 1'b1;
    in_stb = 1'b1;
    in_data = 8'h77;
    #1;
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_ack", int'(in_ack), 0);
    chk("mid_rst_de", int'(pix_de), 0);
    chk("mid_rst_sync", int'(frame_sync), 1);
    chk("mid_rst_uf", int'(underflow_cnt), 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    in_stb = 1'b0;
    #1;
    chk("release_sync", int'(frame_sync), 1);
    chk("release_level", int'(level), 0);
    repeat (120) @(negedge clk);
    chk("restart_sync", int'(frame_sync), 1);
    chk("restart_uf", int'(underflow_cnt), 40);

    g = 0;
    while (!sat_done && g < 70000) begin
      @(negedge clk);
      g++;
    end
    if (!sat_done) begin
      vectors++;
      errs++;
      $display("FAIL sat_timeout: got not done, expected done");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  // Starved all-active instance: one underflow per clock until saturation
  initial begin
    repeat (2) @(negedge clk);
    #2;
    rst_s = 1'b0;
    repeat (65534) @(negedge clk);
    chk("sat_pre", int'(s_ucnt), 16'hFFFE);
    @(negedge clk);
    chk("sat_hit", int'(s_ucnt), 16'hFFFF);
    chk("sat_fs", int'(s_fs), 0);
    repeat (3) @(negedge clk);
    chk("sat_hold", int'(s_ucnt), 16'hFFFF);
    chk("sat_pix", int'(s_pix), 0);
    chk("sat_de", int'(s_de), 1);
    chk("sat_ack", int'(s_ack), 0);
    chk("sat_level", int'(s_level), 0);
    sat_done = 1'b1;
  end

endmodule
